// File: rtl/vga_scan_gen.sv
// ============================================================================
// vga_scan_gen: raster counters, sync generation and registered pixel output.
// Rev 1.0 - optional clk/2 pixel tick when VGA_SCAN_PIXDIV_EN is defined.
// ============================================================================
`default_nettype none

module vga_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] col,
  output logic [9:0] row,
  input  logic [2:0] rgb_in,
  output logic [2:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       tick;
  logic [9:0] col_q, col_d, row_q, row_d;
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic       vis0, hs0, vs0;

`ifdef VGA_SCAN_PIXDIV_EN
  // Toggle flop resets to 0 so the first tick lands on the second clk.
  logic div_q, div_d;

  always_comb div_d = ~div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= 1'b0;
    else       div_q <= div_d;
  end

  assign tick = div_q;
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (col_q == H_LAST) begin
        col_d = 10'd0;
        if (row_q == V_LAST) begin
          row_d         = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          row_d = row_q + 10'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_comb begin
    vis0 = (col_q < H_VIS) && (row_q < V_VIS);
    hs0  = !((col_q >= HS_START) && (col_q < HS_END));
    vs0  = !((row_q >= VS_START) && (row_q < VS_END));
  end

  // Stage 1 holds between ticks; blanking forces black regardless of rgb_in.
  always_comb begin
    rgb_d      = rgb_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    if (tick) begin
      rgb_d      = vis0 ? rgb_in : 3'b000;
      hsync_d    = hs0;
      vsync_d    = vs0;
      video_on_d = vis0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q         <= 10'd0;
      row_q         <= 10'd0;
      rgb_q         <= 3'b000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
// ============================================================================
// tb_vga_scan_gen: directed bench for vga_scan_gen (full-size and small raster).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_scan_gen;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Full-size 800x525 instance; rgb_in mimics a sprite decoding the position.
  logic [9:0] b_col, b_row;
  logic [2:0] b_rgb_in, b_rgb;
  logic       b_hs, b_vs, b_von, b_fs;
  assign b_rgb_in = b_col[2:0] ^ b_row[2:0];

  vga_scan_gen u_big (
    .clk(clk), .reset(reset), .col(b_col), .row(b_row), .rgb_in(b_rgb_in),
    .rgb(b_rgb), .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .frame_start(b_fs)
  );

  // Small 15x8 raster so whole frames fit in a short run.
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;

  logic [9:0] s_col, s_row;
  logic [2:0] s_rgb;
  logic       s_hs, s_vs, s_von, s_fs;
  logic [2:0] s_rgb_in = 3'b111;

  vga_scan_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk(clk), .reset(reset), .col(s_col), .row(s_row), .rgb_in(s_rgb_in),
    .rgb(s_rgb), .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .frame_start(s_fs)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int mbc, mbr, msc, msr, pc, pr;
    int e_b_pos, e_b_out, e_s_pos, e_s_out;
    int hs_first, hs_low, vs_low, s_rgb7, fs_cnt, fs_first;
    logic exp_fs, vis, hs, vs;
    logic [2:0] exp_rgb;

    mbc = 0; mbr = 0; msc = 0; msr = 0;
    e_b_pos = 0; e_b_out = 0; e_s_pos = 0; e_s_out = 0;
    hs_first = 0; hs_low = 0; vs_low = 0; s_rgb7 = 0; fs_cnt = 0; fs_first = 0;

    // Reset held for 5 clocks.
    repeat (5) @(posedge clk);
    #1;
    check("rst_col",   32'(b_col), 0);
    check("rst_row",   32'(b_row), 0);
    check("rst_rgb",   32'(b_rgb), 0);
    check("rst_hsync", 32'(b_hs),  1);
    check("rst_vsync", 32'(b_vs),  1);
    check("rst_von",   32'(b_von), 0);
    check("rst_fs",    32'(b_fs),  0);
    check("rst_s_col", 32'(s_col), 0);

    @(negedge clk);
    reset = 1'b0;

    for (int n = 1; n <= 1900; n++) begin
      @(posedge clk);
      #1;
      // Full-size model: outputs reflect the position presented before this edge.
      pc = mbc; pr = mbr;
      exp_fs = (mbc == 799) && (mbr == 524);
      if (mbc == 799) begin
        mbc = 0;
        mbr = (mbr == 524) ? 0 : mbr + 1;
      end else begin
        mbc = mbc + 1;
      end
      vis = (pc < 640) && (pr < 480);
      hs  = !((pc >= 656) && (pc < 752));
      vs  = !((pr >= 490) && (pr < 492));
      exp_rgb = vis ? 3'((pc ^ pr) & 7) : 3'b000;
      if (b_col !== 10'(mbc) || b_row !== 10'(mbr)) e_b_pos++;
      if (b_rgb !== exp_rgb || b_hs !== hs || b_vs !== vs || b_von !== vis || b_fs !== exp_fs)
        e_b_out++;
      if (n <= 800) begin
        if (b_hs == 1'b0) hs_low++;
        if (b_hs == 1'b0 && hs_first == 0) hs_first = n;
      end
      if (n == 1) begin
        check("first_col", 32'(b_col), 1);
        check("first_fs",  32'(b_fs),  0);
      end
      if (n == 800) begin
        check("wrap_col", 32'(b_col), 0);
        check("wrap_row", 32'(b_row), 1);
      end

      // Small-raster model.
      pc = msc; pr = msr;
      exp_fs = (msc == SHT - 1) && (msr == SVT - 1);
      if (msc == SHT - 1) begin
        msc = 0;
        msr = (msr == SVT - 1) ? 0 : msr + 1;
      end else begin
        msc = msc + 1;
      end
      vis = (pc < SHV) && (pr < SVV);
      hs  = !((pc >= SHV + SHF) && (pc < SHV + SHF + SHS));
      vs  = !((pr >= SVV + SVF) && (pr < SVV + SVF + SVS));
      exp_rgb = vis ? 3'b111 : 3'b000;
      if (s_col !== 10'(msc) || s_row !== 10'(msr)) e_s_pos++;
      if (s_rgb !== exp_rgb || s_hs !== hs || s_vs !== vs || s_von !== vis || s_fs !== exp_fs)
        e_s_out++;
      if (n <= SHT * SVT) begin
        if (s_vs == 1'b0) vs_low++;
        if (s_rgb == 3'b111) s_rgb7++;
      end
      if (s_fs == 1'b1) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = n;
      end
    end

    check("big_pos_errs",   32'(e_b_pos), 0);
    check("big_out_errs",   32'(e_b_out), 0);
    check("hsync_fall_at",  32'(hs_first), 657);
    check("hsync_low_len",  32'(hs_low), 96);
    check("small_pos_errs", 32'(e_s_pos), 0);
    check("small_out_errs", 32'(e_s_out), 0);
    check("vsync_low_len",  32'(vs_low), SVS * SHT);
    check("small_vis_px",   32'(s_rgb7), SHV * SVV);
    check("fs_first_at",    32'(fs_first), SHT * SVT);
    check("fs_count",       32'(fs_cnt), 1900 / (SHT * SVT));

    // Mid-line asynchronous reset at col 300, row 2.
    check("pre_rst_col", 32'(b_col), 300);
    check("pre_rst_row", 32'(b_row), 2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_col",   32'(b_col), 0);
    check("arst_row",   32'(b_row), 0);
    check("arst_rgb",   32'(b_rgb), 0);
    check("arst_hsync", 32'(b_hs),  1);
    check("arst_vsync", 32'(b_vs),  1);
    check("arst_von",   32'(b_von), 0);
    check("arst_s_row", 32'(s_row), 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rel_col", 32'(b_col), 1);
    check("rel_row", 32'(b_row), 0);
    check("rel_von", 32'(b_von), 1);
    check("rel_fs",  32'(b_fs),  0);
    @(posedge clk);
    #1;
    check("rel_rgb", 32'(b_rgb), 1);
    check("rel_col2", 32'(b_col), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
